// File: rtl/array_stream_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : array_stream_serializer_if
// Purpose  : Handshake bundle for array_stream_serializer. Carries the wide
//            input array channel and the narrow output beat channel.
// Signals  : in_valid/in_ready/in_array   - input array channel
//            out_valid/out_ready/out_data - output beat channel
//            out_beat/out_last            - beat index and final-beat flag
// Modports : master - producer of arrays / consumer of beats (environment)
//            slave  - the serializer itself
// Revision : 1.0 - initial release
// ============================================================================
interface array_stream_serializer_if #(
  parameter int D1  = 8,
  parameter int D2  = 4,
  parameter int EPB = 2
);
  localparam int NUM_BEATS = D1 / EPB;
  localparam int BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  logic                    in_valid;
  logic                    in_ready;
  logic [D1-1:0][D2-1:0]   in_array;
  logic                    out_valid;
  logic                    out_ready;
  logic [EPB*D2-1:0]       out_data;
  logic [BW-1:0]           out_beat;
  logic                    out_last;

  modport master (
    output in_valid, in_array, out_ready,
    input  in_ready, out_valid, out_data, out_beat, out_last
  );

  modport slave (
    input  in_valid, in_array, out_ready,
    output in_ready, out_valid, out_data, out_beat, out_last
  );
endinterface
`default_nettype wire

// File: rtl/array_stream_serializer.sv
`default_nettype none
// ============================================================================
// Module   : array_stream_serializer
// Purpose  : Captures a packed D1 x D2 array over a valid/ready handshake and
//            streams it out as NUM_BEATS = D1/EPB beats of EPB elements each,
//            with beat index and last flag. A new array can be captured on the
//            final-beat handshake, so consecutive arrays stream without gaps.
// Ports    : clk   - clock, rising edge
//            rstn  - asynchronous active-low reset
//            flush - synchronous abort of the array in flight (highest prio)
//            bus   - array_stream_serializer_if.slave (array in, beats out)
// Options  : ARRAY_STREAM_SER_MSB_FIRST_EN - when defined, beats are emitted
//            highest element group first; out_beat still counts 0 upward.
// Notes    : in_ready depends combinationally on out_ready, but only while
//            the final beat is presented. out_data/out_beat/out_last come
//            from registers only.
// Revision : 1.0 - initial release
// ============================================================================
module array_stream_serializer #(
  parameter int D1  = 8,
  parameter int D2  = 4,
  parameter int EPB = 2
) (
  input  wire logic              clk,
  input  wire logic              rstn,
  input  wire logic              flush,
  array_stream_serializer_if.slave bus
);

  localparam int NUM_BEATS = D1 / EPB;
  localparam int BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int c_beat_w  = EPB * D2;
  localparam logic [BW-1:0] c_last_beat = BW'(NUM_BEATS - 1);

  if ((EPB < 1) || (EPB > D1) || ((D1 % EPB) != 0)) begin : g_bad_cfg
    $error("array_stream_serializer: EPB must be in 1..D1 and divide D1");
  end

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t              r_state;
  logic [D1*D2-1:0]    r_hold;
  logic [BW-1:0]       r_beat;
  logic                r_last;

  logic                w_in_ready;
  logic                w_accept;
  logic                w_out_fire;
  logic [BW-1:0]       w_sel;
  logic [c_beat_w-1:0] w_data;

  assign w_out_fire = (r_state == S_BUSY) & bus.out_ready;
  // Ready while idle, or when the final beat leaves this cycle so the next
  // array lands with no bubble. Flush blocks any capture.
  assign w_in_ready = ~flush & ((r_state == S_IDLE) | (bus.out_ready & r_last));
  assign w_accept   = bus.in_valid & w_in_ready;

`ifdef ARRAY_STREAM_SER_MSB_FIRST_EN
  assign w_sel = c_last_beat - r_beat;
`else
  assign w_sel = r_beat;
`endif

  // Element group selected by the beat counter; held register keeps the
  // payload stable under backpressure.
  always_comb begin
    w_data = '0;
    for (int b = 0; b < NUM_BEATS; b++) begin
      if (w_sel == BW'(b)) begin
        w_data = r_hold[b*c_beat_w +: c_beat_w];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
      r_beat  <= '0;
      r_last  <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_last  <= 1'b0;
    end else if (w_accept) begin
      // Covers both the idle capture and the back-to-back capture on the
      // final-beat handshake.
      r_state <= S_BUSY;
      r_hold  <= bus.in_array;
      r_beat  <= '0;
      r_last  <= (NUM_BEATS == 1);
    end else if (w_out_fire) begin
      if (r_last) begin
        r_state <= S_IDLE;
        r_beat  <= '0;
        r_last  <= 1'b0;
      end else begin
        r_beat  <= r_beat + 1'b1;
        r_last  <= ((r_beat + 1'b1) == c_last_beat);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_BUSY);
  assign bus.out_data  = w_data;
  assign bus.out_beat  = r_beat;
  assign bus.out_last  = r_last;

endmodule
`default_nettype wire
